// File: rtl/dcache_pkg.sv
// Shared types and defaults for the direct-mapped L1 data cache controller.
// Optional build macro used by this slice: DCACHE_PERF_CNT_EN (hit/miss counters).
package dcache_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LINES  = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        MISS_REQ  = 3'd2,
        MISS_WAIT = 3'd3,
        WR_REQ    = 3'd4,
        RESP      = 3'd5,
        FLUSH     = 3'd6
    } dcache_state_e;

    // Tag width left after removing the byte offset (2 bits) and the index.
    function automatic int calc_tag_w(input int addr_w, input int lines);
        return addr_w - 2 - $clog2(lines);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage for the direct-mapped cache: one word per line.
// Combinational read, synchronous line write and synchronous invalidate-all.
// Only the valid bits are reset; tag and data contents are don't-care until valid.
module dcache_array #(
    parameter int LINES  = 32,
    parameter int IDX_W  = 5,
    parameter int TAG_W  = 25,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic              rd_valid,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              inv_all
);

    logic [LINES-1:0]  valid_r;
    logic [TAG_W-1:0]  tag_mem_r  [LINES];
    logic [DATA_W-1:0] data_mem_r [LINES];

    // Valid bits: cleared by reset or invalidate-all, set by any line write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r <= '0;
        end else if (inv_all) begin
            valid_r <= '0;
        end else if (wr_en) begin
            valid_r[wr_idx] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data storage, written together on refill or store hit.
    always_ff @(posedge clk) begin
        if (wr_en && !inv_all) begin
            tag_mem_r[wr_idx]  <= wr_tag;
            data_mem_r[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_r[rd_idx];
    assign rd_tag   = tag_mem_r[rd_idx];
    assign rd_data  = data_mem_r[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache controller.
// One LSU request in flight; refills one word per line from the memory port.
// Build option: define DCACHE_PERF_CNT_EN to add saturating perf_hits/perf_misses outputs.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LINES  = DEF_LINES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_rdata,
    output logic              cpu_resp_hit,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
`ifdef DCACHE_PERF_CNT_EN
    input  logic [DATA_W-1:0] mem_resp_rdata,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses
`else
    input  logic [DATA_W-1:0] mem_resp_rdata
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = calc_tag_w(ADDR_W, LINES);

    dcache_state_e     state_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              hit_r;

    logic [IDX_W-1:0]  idx_s;
    logic [TAG_W-1:0]  tag_s;
    logic              rd_valid_s;
    logic [TAG_W-1:0]  rd_tag_s;
    logic [DATA_W-1:0] rd_data_s;
    logic              hit_s;
    logic              arr_wr_en_s;
    logic [DATA_W-1:0] arr_wr_data_s;
    logic              inv_all_s;
    logic              unused_s;

    // Byte-offset bits of the request address never reach the cache.
    assign unused_s = ^cpu_req_addr[1:0];

    assign idx_s     = addr_r[2 +: IDX_W];
    assign tag_s     = addr_r[ADDR_W-1 -: TAG_W];
    assign hit_s     = rd_valid_s && (rd_tag_s == tag_s);
    assign inv_all_s = (state_r == FLUSH);

    // Flush wins over a request arriving in the same IDLE cycle.
    assign cpu_req_ready = (state_r == IDLE) && !flush;

    dcache_array #(
        .LINES  (LINES),
        .IDX_W  (IDX_W),
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (idx_s),
        .rd_valid (rd_valid_s),
        .rd_tag   (rd_tag_s),
        .rd_data  (rd_data_s),
        .wr_en    (arr_wr_en_s),
        .wr_idx   (idx_s),
        .wr_tag   (tag_s),
        .wr_data  (arr_wr_data_s),
        .inv_all  (inv_all_s)
    );

    // Array write source: store hit updates in LOOKUP, refill lands in MISS_WAIT.
    always_comb begin
        arr_wr_en_s   = 1'b0;
        arr_wr_data_s = wdata_r;
        if ((state_r == LOOKUP) && we_r && hit_s) begin
            arr_wr_en_s   = 1'b1;
            arr_wr_data_s = wdata_r;
        end else if ((state_r == MISS_WAIT) && mem_resp_valid) begin
            arr_wr_en_s   = 1'b1;
            arr_wr_data_s = mem_resp_rdata;
        end else begin
            arr_wr_en_s   = 1'b0;
            arr_wr_data_s = wdata_r;
        end
    end

    // Request sequencing FSM with registered CPU and memory outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            we_r           <= 1'b0;
            addr_r         <= '0;
            wdata_r        <= '0;
            hit_r          <= 1'b0;
            cpu_resp_valid <= 1'b0;
            cpu_resp_rdata <= '0;
            cpu_resp_hit   <= 1'b0;
            mem_req_valid  <= 1'b0;
            mem_req_we     <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_wdata  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (flush) begin
                        state_r <= FLUSH;
                    end else if (cpu_req_valid) begin
                        we_r    <= cpu_req_we;
                        addr_r  <= {cpu_req_addr[ADDR_W-1:2], 2'b00};
                        wdata_r <= cpu_req_wdata;
                        state_r <= LOOKUP;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FLUSH: begin
                    state_r <= IDLE;
                end
                LOOKUP: begin
                    hit_r <= hit_s;
                    if (we_r) begin
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= 1'b1;
                        mem_req_addr  <= addr_r;
                        mem_req_wdata <= wdata_r;
                        state_r       <= WR_REQ;
                    end else if (hit_s) begin
                        cpu_resp_valid <= 1'b1;
                        cpu_resp_rdata <= rd_data_s;
                        cpu_resp_hit   <= 1'b1;
                        state_r        <= RESP;
                    end else begin
                        mem_req_valid <= 1'b1;
                        mem_req_we    <= 1'b0;
                        mem_req_addr  <= addr_r;
                        mem_req_wdata <= '0;
                        state_r       <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_req_addr  <= '0;
                        state_r       <= MISS_WAIT;
                    end else begin
                        state_r <= MISS_REQ;
                    end
                end
                MISS_WAIT: begin
                    if (mem_resp_valid) begin
                        cpu_resp_valid <= 1'b1;
                        cpu_resp_rdata <= mem_resp_rdata;
                        cpu_resp_hit   <= 1'b0;
                        state_r        <= RESP;
                    end else begin
                        state_r <= MISS_WAIT;
                    end
                end
                WR_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid  <= 1'b0;
                        mem_req_we     <= 1'b0;
                        mem_req_addr   <= '0;
                        mem_req_wdata  <= '0;
                        cpu_resp_valid <= 1'b1;
                        cpu_resp_rdata <= '0;
                        cpu_resp_hit   <= hit_r;
                        state_r        <= RESP;
                    end else begin
                        state_r <= WR_REQ;
                    end
                end
                RESP: begin
                    cpu_resp_valid <= 1'b0;
                    cpu_resp_rdata <= '0;
                    cpu_resp_hit   <= 1'b0;
                    state_r        <= IDLE;
                end
                default: begin
                    cpu_resp_valid <= 1'b0;
                    mem_req_valid  <= 1'b0;
                    state_r        <= IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    // Saturating hit/miss counters sampled on every lookup, loads and stores alike.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_hits   <= 32'd0;
            perf_misses <= 32'd0;
        end else if (state_r == LOOKUP) begin
            if (hit_s) begin
                if (perf_hits != 32'hFFFF_FFFF) begin
                    perf_hits <= perf_hits + 32'd1;
                end else begin
                    perf_hits <= perf_hits;
                end
            end else begin
                if (perf_misses != 32'hFFFF_FFFF) begin
                    perf_misses <= perf_misses + 32'd1;
                end else begin
                    perf_misses <= perf_misses;
                end
            end
        end else begin
            perf_hits   <= perf_hits;
            perf_misses <= perf_misses;
        end
    end
`endif

endmodule
